// File: rtl/pingpong_buf_pkg.sv
// Shared definitions for the ping-pong buffers: bank-state encoding and
// per-path geometry for the weight, activation and psum instances.
// Latency: n/a (package). Backpressure: n/a.
package pingpong_buf_pkg;

  // Ownership state of one bank.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Per-path geometry for the buffer instances.
  localparam int WGT_DATA_W  = 64;
  localparam int WGT_DEPTH   = 256;
  localparam int ACT_DATA_W  = 64;
  localparam int ACT_DEPTH   = 512;
  localparam int PSUM_DATA_W = 32;
  localparam int PSUM_DEPTH  = 128;

endpackage

// File: rtl/pingpong_bank.sv
// One bank of the ping-pong buffer: simple-dual-port array, sync write, registered read.
// Latency: read data 1 cycle after re; write lands on the edge where we is high.
// Backpressure: none; callers gate we/re and keep addresses in range.
//
// Ports: clk; we/waddr/wdata (+wmask when PINGPONG_BUF_WMASK_EN) write port;
//        re/raddr read port; rdata holds the last read word until the next re.
// Optional macro: PINGPONG_BUF_WMASK_EN adds the per-byte write mask.
module pingpong_bank #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`ifdef PINGPONG_BUF_WMASK_EN
  input  logic [DATA_W/8-1:0] wmask,
`endif
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or the read register: the top masks stale data.
  always_ff @(posedge clk) begin
    if (we) begin
`ifdef PINGPONG_BUF_WMASK_EN
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wmask[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
`else
      mem[waddr] <= wdata;
`endif
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_buf.sv
// Double-banked buffer: producer fills one bank while the consumer drains the other.
// Latency: read data 1 cycle after an accepted rd_en; committed data readable next cycle.
// Backpressure: wr_ready/rd_ready gate strobes; ignored strobes pulse err_drop next cycle.
//
// Ports: clk, rst (sync, active-high);
//        write side wr_en/wr_addr/wr_data/wr_commit -> wr_ready/wr_bank;
//        read side rd_en/rd_addr/rd_release -> rd_data/rd_valid/rd_ready/rd_bank;
//        err_drop flags a dropped strobe or an out-of-range write address.
// Optional macro: PINGPONG_BUF_WMASK_EN adds wr_mask (one bit per byte lane).
module pingpong_buf
  import pingpong_buf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef PINGPONG_BUF_WMASK_EN
  input  logic [DATA_W/8-1:0] wr_mask,
`endif
  input  logic              wr_commit,
  output logic              wr_ready,
  output logic              wr_bank,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              rd_ready,
  output logic              rd_bank,
  output logic              err_drop
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  bank_state_e bank_state_q [2];
  bank_state_e bank_state_d [2];
  logic        wbank_q, wbank_d;
  logic        rbank_q, rbank_d;

  logic        rd_valid_q;
  logic        rd_sel_q;   // bank that produced the held read word
  logic        rd_zero_q;  // held read word is zero (reset or out-of-range read)
  logic        err_q;

  logic [DATA_W-1:0] bank_rdata [2];
  logic [1:0]        bank_we;
  logic [1:0]        bank_re;

  logic wr_in_range, rd_in_range;
  logic wr_acc, rd_acc, commit_ok, release_ok, drop;

  assign wr_ready = (bank_state_q[wbank_q] == BANK_EMPTY);
  assign rd_ready = (bank_state_q[rbank_q] == BANK_FULL);
  assign wr_bank  = wbank_q;
  assign rd_bank  = rbank_q;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

  assign wr_acc     = wr_en & wr_ready & wr_in_range;
  assign rd_acc     = rd_en & rd_ready;
  assign commit_ok  = wr_commit & wr_ready;
  assign release_ok = rd_release & rd_ready;

  assign drop = ((wr_en | wr_commit) & ~wr_ready)
              | ((rd_en | rd_release) & ~rd_ready)
              | (wr_en & wr_ready & ~wr_in_range);

  // Bank ownership. When wbank==rbank the bank is either EMPTY or FULL, so
  // only one of commit_ok/release_ok can be true and they never collide.
  always_comb begin
    bank_state_d[0] = bank_state_q[0];
    bank_state_d[1] = bank_state_q[1];
    wbank_d         = wbank_q;
    rbank_d         = rbank_q;
    if (commit_ok) begin
      bank_state_d[wbank_q] = BANK_FULL;
      wbank_d               = ~wbank_q;
    end
    if (release_ok) begin
      bank_state_d[rbank_q] = BANK_EMPTY;
      rbank_d               = ~rbank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state_q[0] <= BANK_EMPTY;
      bank_state_q[1] <= BANK_EMPTY;
      wbank_q         <= 1'b0;
      rbank_q         <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_sel_q        <= 1'b0;
      rd_zero_q       <= 1'b1;
      err_q           <= 1'b0;
    end else begin
      bank_state_q[0] <= bank_state_d[0];
      bank_state_q[1] <= bank_state_d[1];
      wbank_q         <= wbank_d;
      rbank_q         <= rbank_d;
      rd_valid_q      <= rd_acc;
      err_q           <= drop;
      if (rd_acc) begin
        rd_sel_q  <= rbank_q;
        rd_zero_q <= ~rd_in_range;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_acc & (wbank_q == 1'(b));
    assign bank_re[b] = rd_acc & rd_in_range & (rbank_q == 1'(b));

    pingpong_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (wr_addr),
      .wdata (wr_data),
`ifdef PINGPONG_BUF_WMASK_EN
      .wmask (wr_mask),
`endif
      .re    (bank_re[b]),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Each bank's read register only moves on its own read, so selecting by
  // the last-read bank holds rd_data steady between reads.
  assign rd_data  = rd_zero_q ? '0 : bank_rdata[rd_sel_q];
  assign rd_valid = rd_valid_q;
  assign err_drop = err_q;

endmodule

// File: tb/tb_pingpong_buf.sv
module tb_pingpong_buf;

  logic        clk = 1'b0;
  logic        rst;
  // main instance: 64-bit x 256
  logic        wr_en, wr_commit, rd_en, rd_release;
  logic [7:0]  wr_addr, rd_addr;
  logic [63:0] wr_data, rd_data;
  logic        wr_ready, wr_bank, rd_valid, rd_ready, rd_bank, err_drop;
`ifdef PINGPONG_BUF_WMASK_EN
  logic [7:0]  wr_mask;
`endif
  // small instance: 8-bit x 5, exercises out-of-range addresses
  logic        s_wr_en, s_wr_commit, s_rd_en, s_rd_release;
  logic [2:0]  s_wr_addr, s_rd_addr;
  logic [7:0]  s_wr_data, s_rd_data;
  logic        s_wr_ready, s_wr_bank, s_rd_valid, s_rd_ready, s_rd_bank, s_err_drop;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q [$];

  always #5 clk = ~clk;

  pingpong_buf #(.DATA_W(64), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef PINGPONG_BUF_WMASK_EN
    .wr_mask(wr_mask),
`endif
    .wr_commit(wr_commit), .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .rd_ready(rd_ready), .rd_bank(rd_bank),
    .err_drop(err_drop)
  );

  pingpong_buf #(.DATA_W(8), .DEPTH(5)) dut_small (
    .clk(clk), .rst(rst),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
`ifdef PINGPONG_BUF_WMASK_EN
    .wr_mask(1'b1),
`endif
    .wr_commit(s_wr_commit), .wr_ready(s_wr_ready), .wr_bank(s_wr_bank),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .rd_release(s_rd_release), .rd_ready(s_rd_ready), .rd_bank(s_rd_bank),
    .err_drop(s_err_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_unexpected: got rd_data 0x%0h with no read pending at %0t", rd_data, $time);
      end else begin
        chk("rd_data", rd_data, sb_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [63:0] wd;
    logic        wc;
    logic        re;
    logic [7:0]  ra;
    logic        rr;
    logic        push;
    logic [63:0] exp_rd;
    logic        e_wr_ready, e_rd_ready, e_wr_bank, e_rd_bank, e_err;
  } vec_t;

  vec_t vecs [16];

  task automatic idle_inputs();
    wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    wr_addr = 8'd0; rd_addr = 8'd0; wr_data = 64'd0;
    s_wr_en = 1'b0; s_wr_commit = 1'b0; s_rd_en = 1'b0; s_rd_release = 1'b0;
    s_wr_addr = 3'd0; s_rd_addr = 3'd0; s_wr_data = 8'd0;
  endtask

  initial begin
    // Table is applied after bank 0 holds data==addr for all 256 words.
    //             we    wa      wd             wc    re    ra       rr    push  exp_rd         wrr   rdr   wb    rb    err
    vecs[0]  = '{1'b0, 8'd0,  64'd0,         1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 64'd0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b1, 8'd17,  1'b0, 1'b1, 64'd17,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'd3,  64'h1003,      1'b0, 1'b1, 8'd200, 1'b0, 1'b1, 64'd200,       1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'd17, 64'hBEEF,      1'b1, 1'b1, 8'd5,   1'b1, 1'b1, 64'd5,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b1, 8'd17,  1'b0, 1'b1, 64'hBEEF,      1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b1, 8'd3,   1'b0, 1'b1, 64'h1003,      1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'd17, 64'h5555,      1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 64'd0,         1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'd3,  64'hDEAD,      1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 64'd0,         1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'd0,  64'd0,         1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 64'd0,         1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 64'd0,         1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b1, 8'd3,   1'b1, 1'b1, 64'h1003,      1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b1, 8'd17,  1'b0, 1'b1, 64'h5555,      1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 64'd0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 64'd0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'd0,  64'd0,         1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 64'd0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 8'd0,  64'd0,         1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 64'd0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    idle_inputs();
`ifdef PINGPONG_BUF_WMASK_EN
    wr_mask = 8'hFF;
`endif
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset / idle state
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_err_drop", err_drop, 0);

    // Small instance: address range boundaries (DEPTH=5)
    s_wr_en = 1'b1; s_wr_addr = 3'd6; s_wr_data = 8'h11;
    step();
    chk("s_oor_wr_err", s_err_drop, 1);
    chk("s_oor_wr_ready", s_wr_ready, 1);
    s_wr_addr = 3'd2; s_wr_data = 8'hAB; s_wr_commit = 1'b1;
    step();
    chk("s_commit_err", s_err_drop, 0);
    chk("s_commit_rd_ready", s_rd_ready, 1);
    chk("s_commit_wr_bank", s_wr_bank, 1);
    s_wr_commit = 1'b0; s_wr_addr = 3'd4; s_wr_data = 8'h44;
    s_rd_en = 1'b1; s_rd_addr = 3'd2;
    step();
    chk("s_rd2_valid", s_rd_valid, 1);
    chk("s_rd2_data", s_rd_data, 8'hAB);
    chk("s_last_addr_err", s_err_drop, 0);
    s_wr_addr = 3'd5; s_wr_data = 8'h55; s_rd_addr = 3'd7;
    step();
    chk("s_rd_oor_valid", s_rd_valid, 1);
    chk("s_rd_oor_data", s_rd_data, 0);
    chk("s_wr_depth_err", s_err_drop, 1);
    s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_commit = 1'b1; s_rd_release = 1'b1;
    step();
    chk("s_swap_rd_bank", s_rd_bank, 1);
    chk("s_swap_wr_bank", s_wr_bank, 0);
    chk("s_swap_rd_valid", s_rd_valid, 0);
    s_wr_commit = 1'b0; s_rd_release = 1'b0; s_rd_en = 1'b1; s_rd_addr = 3'd4;
    step();
    chk("s_rd4_data", s_rd_data, 8'h44);
    s_rd_en = 1'b0;

    // Main instance: fill bank 0 with data == addr
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = 64'(a);
      step();
    end
    idle_inputs();
    chk("fill_rd_ready", rd_ready, 0);

    for (int i = 0; i < 16; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      wr_commit = vecs[i].wc; rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      rd_release = vecs[i].rr;
      if (vecs[i].push) sb_q.push_back(vecs[i].exp_rd);
      step();
      chk($sformatf("v%0d_wr_ready", i), wr_ready, vecs[i].e_wr_ready);
      chk($sformatf("v%0d_rd_ready", i), rd_ready, vecs[i].e_rd_ready);
      chk($sformatf("v%0d_wr_bank", i), wr_bank, vecs[i].e_wr_bank);
      chk($sformatf("v%0d_rd_bank", i), rd_bank, vecs[i].e_rd_bank);
      chk($sformatf("v%0d_err_drop", i), err_drop, vecs[i].e_err);
    end
    idle_inputs();
    step();

    // Reset in the middle of a fill (bank 1 is FULL and being read)
    for (int a = 0; a < 100; a++) begin
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = 64'(a + 1000);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 8'd3; rst = 1'b1;
    step();
    rst = 1'b0; rd_en = 1'b0;
    chk("mid_rst_wr_ready", wr_ready, 1);
    chk("mid_rst_rd_ready", rd_ready, 0);
    chk("mid_rst_wr_bank", wr_bank, 0);
    chk("mid_rst_rd_bank", rd_bank, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    step();
    chk("post_rst_rd_valid", rd_valid, 0);

`ifdef PINGPONG_BUF_WMASK_EN
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; wr_mask = 8'hFF;
    step();
    wr_data = 64'd0; wr_mask = 8'h0F;
    step();
    wr_addr = 8'd1; wr_data = 64'hAA; wr_mask = 8'h00;
    step();
    chk("mask_prev_err", err_drop, 0);
    wr_en = 1'b0; wr_mask = 8'hFF; wr_commit = 1'b1;
    step();
    chk("mask_zero_err", err_drop, 0);
    wr_commit = 1'b0; rd_en = 1'b1; rd_addr = 8'd0;
    sb_q.push_back(64'hFFFF_FFFF_0000_0000);
    step();
    rd_en = 1'b0;
`else
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 64'h0123_4567_89AB_CDEF;
    step();
    wr_en = 1'b0; wr_commit = 1'b1;
    step();
    chk("post_rst_commit_rd_ready", rd_ready, 1);
    chk("post_rst_commit_wr_bank", wr_bank, 1);
    wr_commit = 1'b0; rd_en = 1'b1; rd_addr = 8'd0;
    sb_q.push_back(64'h0123_4567_89AB_CDEF);
    step();
    rd_en = 1'b0;
`endif

    step();
    step();
    step();
    chk("sb_drained", 64'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
